// File: rtl/alu_arbiter.sv
// Two-requester front end sharing a single ALU: round-robin grant, one-deep
// registered response with single-cycle latency and full back-to-back throughput.

package alu_arbiter_pkg;
  localparam logic [4:0] ALU_EXEC_ADD  = 5'd0;
  localparam logic [4:0] ALU_EXEC_SUB  = 5'd1;
  localparam logic [4:0] ALU_EXEC_AND  = 5'd2;
  localparam logic [4:0] ALU_EXEC_OR   = 5'd3;
  localparam logic [4:0] ALU_EXEC_XOR  = 5'd4;
  localparam logic [4:0] ALU_EXEC_SLL  = 5'd5;
  localparam logic [4:0] ALU_EXEC_SRL  = 5'd6;
  localparam logic [4:0] ALU_EXEC_SRA  = 5'd7;
  localparam logic [4:0] ALU_EXEC_SLT  = 5'd8;
  localparam logic [4:0] ALU_EXEC_SLTU = 5'd9;
endpackage

module alu_arbiter_alu #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 5
) (
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  output logic [XLEN-1:0]         result
);
  import alu_arbiter_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    result = '0;
    case (op)
      ALU_OP_WIDTH'(ALU_EXEC_ADD):  result = a + b;
      ALU_OP_WIDTH'(ALU_EXEC_SUB):  result = a - b;
      ALU_OP_WIDTH'(ALU_EXEC_AND):  result = a & b;
      ALU_OP_WIDTH'(ALU_EXEC_OR):   result = a | b;
      ALU_OP_WIDTH'(ALU_EXEC_XOR):  result = a ^ b;
      ALU_OP_WIDTH'(ALU_EXEC_SLL):  result = a << shamt;
      ALU_OP_WIDTH'(ALU_EXEC_SRL):  result = a >> shamt;
      ALU_OP_WIDTH'(ALU_EXEC_SRA):  result = $unsigned($signed(a) >>> shamt);
      ALU_OP_WIDTH'(ALU_EXEC_SLT):  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_OP_WIDTH'(ALU_EXEC_SLTU): result = {{(XLEN-1){1'b0}}, a < b};
      default:                      result = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req0_valid,
  input  logic [ALU_OP_WIDTH-1:0] i_req0_op,
  input  logic [XLEN-1:0]         i_req0_a,
  input  logic [XLEN-1:0]         i_req0_b,
  output logic                    o_req0_ready,
  input  logic                    i_req1_valid,
  input  logic [ALU_OP_WIDTH-1:0] i_req1_op,
  input  logic [XLEN-1:0]         i_req1_a,
  input  logic [XLEN-1:0]         i_req1_b,
  output logic                    o_req1_ready,
  output logic                    o_rsp_valid,
  output logic                    o_rsp_id,
  output logic [XLEN-1:0]         o_rsp_result,
  input  logic                    i_rsp_ready
);

  logic                    last_grant;
  logic                    slot_open;
  logic                    grant0;
  logic                    grant1;
  logic                    accept;
  logic                    sel;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  logic [XLEN-1:0]         alu_result;

  // Gating on reset keeps both readies low while i_rst_n is low.
  assign slot_open = i_rst_n && (!o_rsp_valid || i_rsp_ready);

  // On a tie the requester that did not win last time is served.
  assign grant0 = i_req0_valid && (!i_req1_valid || last_grant);
  assign grant1 = i_req1_valid && (!i_req0_valid || !last_grant);

  assign o_req0_ready = slot_open && grant0;
  assign o_req1_ready = slot_open && grant1;
  assign accept       = o_req0_ready || o_req1_ready;
  assign sel          = o_req1_ready;

  assign alu_op = sel ? i_req1_op : i_req0_op;
  assign alu_a  = sel ? i_req1_a  : i_req0_a;
  assign alu_b  = sel ? i_req1_b  : i_req0_b;

  alu_arbiter_alu #(
    .XLEN         (XLEN),
    .ALU_OP_WIDTH (ALU_OP_WIDTH)
  ) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_grant   <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= 1'b0;
      o_rsp_result <= '0;
    end else if (accept) begin
      last_grant   <= sel;
      o_rsp_valid  <= 1'b1;
      o_rsp_id     <= sel;
      o_rsp_result <= alu_result;
    end else if (i_rsp_ready) begin
      // Drain without a replacement: id/result keep their last values.
      o_rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scenario tasks with a response scoreboard
// queue filled on accepted requests and drained when the consumer takes a response.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int OPW  = 5;

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] result;
  } rsp_t;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_req0_valid;
  logic [OPW-1:0]  i_req0_op;
  logic [XLEN-1:0] i_req0_a;
  logic [XLEN-1:0] i_req0_b;
  logic            o_req0_ready;
  logic            i_req1_valid;
  logic [OPW-1:0]  i_req1_op;
  logic [XLEN-1:0] i_req1_a;
  logic [XLEN-1:0] i_req1_b;
  logic            o_req1_ready;
  logic            o_rsp_valid;
  logic            o_rsp_id;
  logic [XLEN-1:0] o_rsp_result;
  logic            i_rsp_ready;

  int   checks   = 0;
  int   failures = 0;
  rsp_t sb_q[$];

  alu_arbiter #(.XLEN(XLEN), .ALU_OP_WIDTH(OPW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_op    (i_req0_op),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_op    (i_req1_op),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .o_req1_ready (o_req1_ready),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .i_rsp_ready  (i_rsp_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Inputs are driven just after a falling edge; tick() settles, checks the
  // readies, updates the scoreboard, then advances to the next falling edge.
  task automatic tick(input logic er0, input logic er1, input logic [XLEN-1:0] eres);
    rsp_t got;
    rsp_t exp;
    #1;
    checks++;
    if (o_req0_ready !== er0 || o_req1_ready !== er1) begin
      failures++;
      $display("FAIL ready: got r0=%b r1=%b expected r0=%b r1=%b at %0t",
               o_req0_ready, o_req1_ready, er0, er1, $time);
    end
    if (i_rst_n && o_rsp_valid && i_rsp_ready) begin
      got.id = o_rsp_id;
      got.result = o_rsp_result;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d result=%h with empty scoreboard", got.id, got.result);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL rsp: got id=%0d result=%h expected id=%0d result=%h at %0t",
                   got.id, got.result, exp.id, exp.result, $time);
        end
      end
    end
    if (i_rst_n && er0 && i_req0_valid) sb_q.push_back('{id: 1'b0, result: eres});
    else if (i_rst_n && er1 && i_req1_valid) sb_q.push_back('{id: 1'b1, result: eres});
    @(posedge i_clk);
    if (!i_rst_n) sb_q.delete();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_req0_valid = 1'b0; i_req0_op = '0; i_req0_a = '0; i_req0_b = '0;
    i_req1_valid = 1'b0; i_req1_op = '0; i_req1_a = '0; i_req1_b = '0;
  endtask

  task automatic check_rsp_regs(input string name, input logic ev, input logic eid,
                                input logic [XLEN-1:0] eres);
    #1;
    checks++;
    if (o_rsp_valid !== ev || o_rsp_id !== eid || o_rsp_result !== eres) begin
      failures++;
      $display("FAIL %s: got v=%b id=%0d result=%h expected v=%b id=%0d result=%h",
               name, o_rsp_valid, o_rsp_id, o_rsp_result, ev, eid, eres);
    end
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rsp_ready = 1'b1;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    // Requests present during reset must not be accepted.
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    check_rsp_regs("reset_state", 1'b0, 1'b0, '0);
    idle_inputs();
    i_rst_n = 1'b1;
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_single();
    i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_op = ALU_EXEC_ADD; i_req0_a = 32'd5; i_req0_b = 32'd7;
    tick(1'b1, 1'b0, 32'd12);
    idle_inputs();
    check_rsp_regs("single_add", 1'b1, 1'b0, 32'd12);
    tick(1'b0, 1'b0, '0);
    check_rsp_regs("single_drained", 1'b0, 1'b0, 32'd12);
  endtask

  task automatic test_round_robin();
    apply_reset();
    i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_op = ALU_EXEC_SUB; i_req0_a = 32'd10;   i_req0_b = 32'd3;
    i_req1_valid = 1'b1; i_req1_op = ALU_EXEC_XOR; i_req1_a = 32'h0000_00F0; i_req1_b = 32'h0000_00FF;
    tick(1'b1, 1'b0, 32'd7);
    i_req0_valid = 1'b0;
    check_rsp_regs("rr_first", 1'b1, 1'b0, 32'd7);
    tick(1'b0, 1'b1, 32'h0000_000F);
    idle_inputs();
    check_rsp_regs("rr_second", 1'b1, 1'b1, 32'h0000_000F);
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_stall();
    i_rsp_ready = 1'b0;
    i_req1_valid = 1'b1; i_req1_op = ALU_EXEC_ADD; i_req1_a = 32'hFFFF_FFFF; i_req1_b = 32'd1;
    tick(1'b0, 1'b1, 32'd0);
    i_req1_valid = 1'b0;
    i_req0_valid = 1'b1; i_req0_op = ALU_EXEC_OR; i_req0_a = 32'h1200; i_req0_b = 32'h0034;
    for (int i = 0; i < 3; i++) begin
      check_rsp_regs("stall_hold", 1'b1, 1'b1, 32'd0);
      tick(1'b0, 1'b0, '0);
    end
    i_rsp_ready = 1'b1;
    tick(1'b1, 1'b0, 32'h1234);
    idle_inputs();
    check_rsp_regs("stall_release", 1'b1, 1'b0, 32'h1234);
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp0;
    logic [XLEN-1:0] exp1;
    apply_reset();
    i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_op = ALU_EXEC_ADD;
    i_req1_valid = 1'b1; i_req1_op = ALU_EXEC_SLL;
    for (int i = 0; i < 6; i++) begin
      i_req0_a = 32'(100 + i); i_req0_b = 32'(3 * i);
      i_req1_a = 32'(i + 1);   i_req1_b = 32'd4;
      exp0 = 32'(100 + 4 * i);
      exp1 = 32'((i + 1) * 16);
      if (i % 2 == 0) tick(1'b1, 1'b0, exp0);
      else            tick(1'b0, 1'b1, exp1);
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'(i % 2)) begin
        failures++;
        $display("FAIL b2b_id[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, o_rsp_valid, o_rsp_id, i % 2);
      end
    end
    idle_inputs();
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_pending();
    i_rsp_ready = 1'b0;
    i_req0_valid = 1'b1; i_req0_op = ALU_EXEC_AND; i_req0_a = 32'hF0F0_F0F0; i_req0_b = 32'hFFFF_0000;
    tick(1'b1, 1'b0, 32'hF0F0_0000);
    idle_inputs();
    check_rsp_regs("pending_before_reset", 1'b1, 1'b0, 32'hF0F0_0000);
    i_rst_n = 1'b0;
    tick(1'b0, 1'b0, '0);
    check_rsp_regs("reset_discard", 1'b0, 1'b0, '0);
    i_rst_n = 1'b1;
    i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_op = ALU_EXEC_SUB; i_req0_a = 32'd0; i_req0_b = 32'd1;
    i_req1_valid = 1'b1; i_req1_op = ALU_EXEC_ADD; i_req1_a = 32'd2; i_req1_b = 32'd2;
    tick(1'b1, 1'b0, 32'hFFFF_FFFF);
    idle_inputs();
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_slt();
    i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_a = 32'd1; i_req0_b = 32'hFFFF_FFFF;
    i_req0_op = ALU_EXEC_SLTU;
    tick(1'b1, 1'b0, 32'd1);
    i_req0_op = ALU_EXEC_SLT;
    tick(1'b1, 1'b0, 32'd0);
    i_req0_op = ALU_EXEC_SRA; i_req0_a = 32'h8000_0000; i_req0_b = 32'd4;
    tick(1'b1, 1'b0, 32'hF800_0000);
    idle_inputs();
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic drain_check();
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) tick(1'b0, 1'b0, '0);
    checks++;
    if (sb_q.size() != 0 || o_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got %0d outstanding, rsp_valid=%b expected 0 and 0", sb_q.size(), o_rsp_valid);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_rsp_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_back_to_back();
    test_reset_pending();
    test_slt();
    drain_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
